// File: rtl/phoneme_sequencer_pkg.sv
// Shared definitions for the phoneme sequencer: FSM state encodings,
// the default silence code and a small constant helper.
package phoneme_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISPATCH  = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_PAUSE     = 3'd4
    } seq_state_e;

    localparam logic [7:0] DEFAULT_SILENCE_CODE = 8'h00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phoneme_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// Pushes while full and pops while empty are ignored.
module phoneme_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_q];
    assign wr_en    = push && !full && !flush;
    assign rd_en    = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_q <= wr_q + AW'(1);
            end
            if (rd_en) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/phoneme_sequencer.sv
// Queues firmware phoneme codes and plays them back-to-back through the
// phoneme player, with inter-phoneme gaps and timed silence pauses.
module phoneme_sequencer
    import phoneme_sequencer_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 8,
    parameter int         GAP_CYCLES     = 25000,
    parameter logic [7:0] SILENCE_CODE   = DEFAULT_SILENCE_CODE,
    parameter int         SILENCE_CYCLES = 2500000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_valid,
    input  logic [7:0]                  push_phoneme,
    output logic                        push_ready,
    input  logic                        flush,
    input  logic                        clear_overflow,
    output logic                        player_start,
    output logic [7:0]                  player_phoneme,
    input  logic                        player_done,
    output logic                        player_abort,
    output logic                        busy,
    output logic                        idle_irq,
    output logic [$clog2(FIFO_DEPTH):0] queue_count,
    output logic                        overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(max_int(GAP_CYCLES, SILENCE_CYCLES) + 1);

    seq_state_e    state_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    phon_q;
    logic          start_q;
    logic          abort_q;
    logic          irq_q;
    logic          busy_q;
    logic          ovf_q;

    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          push_acc;
    logic          pop;
    logic          pending_d;

    assign push_acc  = push_valid && !full && !flush;
    assign pop       = (state_q == ST_IDLE) && !empty && !flush;
    // Outside IDLE nothing is popped, so this is the next-cycle non-empty flag.
    assign pending_d = (count != '0) || push_acc;

    phoneme_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .push      (push_acc),
        .push_data (push_phoneme),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (push_valid && full && !flush) begin
            ovf_q <= 1'b1;
        end else if (clear_overflow) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            phon_q  <= 8'h00;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            irq_q   <= 1'b0;
            if (flush) begin
                abort_q <= (state_q == ST_WAIT_DONE);
                state_q <= ST_IDLE;
                timer_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                busy_q <= 1'b1;
                unique case (state_q)
                    ST_IDLE: begin
                        if (pop) begin
                            phon_q  <= head;
                            state_q <= ST_DISPATCH;
                        end else begin
                            busy_q <= pending_d;
                        end
                    end
                    ST_DISPATCH: begin
                        if (phon_q == SILENCE_CODE) begin
                            timer_q <= TW'(SILENCE_CYCLES);
                            state_q <= ST_PAUSE;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (player_done) begin
                            if (GAP_CYCLES > 0) begin
                                timer_q <= TW'(GAP_CYCLES);
                                state_q <= ST_GAP;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= pending_d;
                                irq_q   <= !pending_d;
                            end
                        end
                    end
                    ST_GAP, ST_PAUSE: begin
                        if (timer_q <= TW'(1)) begin
                            timer_q <= '0;
                            state_q <= ST_IDLE;
                            busy_q  <= pending_d;
                            irq_q   <= !pending_d;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign push_ready     = !full;
    assign player_start   = start_q;
    assign player_phoneme = phon_q;
    assign player_abort   = abort_q;
    assign busy           = busy_q;
    assign idle_irq       = irq_q;
    assign queue_count    = count;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_phoneme_sequencer.sv
// Scoreboard bench for phoneme_sequencer: directed pushes with
// hand-computed event cycles checked by an independent monitor.
module tb_phoneme_sequencer;
    import phoneme_sequencer_pkg::*;

    localparam int EV_START = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_IRQ   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       push_valid;
    logic [7:0] push_phoneme;
    logic       push_ready;
    logic       flush;
    logic       clear_overflow;
    logic       player_start;
    logic [7:0] player_phoneme;
    logic       player_done;
    logic       player_abort;
    logic       busy;
    logic       idle_irq;
    logic [2:0] queue_count;
    logic       overflow;

    int  cyc = 0;
    int  n_vec = 0;
    int  n_bad = 0;
    ev_t exp_q[$];

    phoneme_sequencer #(
        .FIFO_DEPTH     (4),
        .GAP_CYCLES     (4),
        .SILENCE_CODE   (DEFAULT_SILENCE_CODE),
        .SILENCE_CYCLES (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .push_valid     (push_valid),
        .push_phoneme   (push_phoneme),
        .push_ready     (push_ready),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .player_start   (player_start),
        .player_phoneme (player_phoneme),
        .player_done    (player_done),
        .player_abort   (player_abort),
        .busy           (busy),
        .idle_irq       (idle_irq),
        .queue_count    (queue_count),
        .overflow       (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit hit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h",
                     name, cyc, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data,
                             input int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic match(input int kind, input logic [7:0] data);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: unexpected kind %0d data %0h at cyc %0d",
                     kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind %0d data %0h cyc %0d, expected kind %0d data %0h cyc %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every start/abort/irq pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (player_start) match(EV_START, player_phoneme);
            if (player_abort) match(EV_ABORT, 8'h00);
            if (idle_irq)     match(EV_IRQ, 8'h00);
        end
    end

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_push(input logic [7:0] code);
        push_valid   = 1'b1;
        push_phoneme = code;
        @(negedge clk);
        push_valid   = 1'b0;
    endtask

    task automatic pulse_done();
        player_done = 1'b1;
        @(negedge clk);
        player_done = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_start", player_start, 0);
        chk("rst_abort", player_abort, 0);
        chk("rst_irq", idle_irq, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_phon", player_phoneme, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", push_ready, 1);
    endtask

    initial begin
        int t;
        logic [7:0] codes [4];
        reset          = 1'b1;
        push_valid     = 1'b0;
        push_phoneme   = 8'h00;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        player_done    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // Single phoneme: start 2 cycles after acceptance, gap then irq.
        t = cyc;
        expect_ev(EV_START, 8'h12, t + 3);
        drive_push(8'h12);
        to_cyc(t + 23);
        expect_ev(EV_IRQ, 8'h00, t + 28);
        pulse_done();
        to_cyc(t + 27);
        chk("t1_busy_before", busy, 1);
        to_cyc(t + 28);
        chk("t1_busy_drop", busy, 0);
        to_cyc(t + 30);

        // Sound, silence, sound: pause replaces a player request.
        t = cyc;
        expect_ev(EV_START, 8'h05, t + 3);
        expect_ev(EV_START, 8'h07, t + 24);
        expect_ev(EV_IRQ, 8'h00, t + 31);
        codes[0] = 8'h05;
        codes[1] = DEFAULT_SILENCE_CODE;
        codes[2] = 8'h07;
        for (int i = 0; i < 3; i++) drive_push(codes[i]);
        to_cyc(t + 5);
        pulse_done();
        to_cyc(t + 15);
        chk("t2_count_in_pause", queue_count, 1);
        to_cyc(t + 26);
        pulse_done();
        to_cyc(t + 34);

        // Stalled player: fill the queue, overflow, clear.
        t = cyc;
        expect_ev(EV_START, 8'h21, t + 3);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) clear_overflow = 1'b1;
            drive_push(8'(8'h21 + i));
            clear_overflow = 1'b0;
            if (i == 4) begin
                chk("t3_ready_full", push_ready, 0);
                chk("t3_ovf_not_yet", overflow, 0);
            end
        end
        chk("t3_count_full", queue_count, 4);
        chk("t3_ovf_set", overflow, 1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("t3_ovf_clear", overflow, 0);
        to_cyc(t + 8);
        expect_ev(EV_ABORT, 8'h00, t + 9);
        pulse_flush();
        chk("t3_count_flushed", queue_count, 0);
        to_cyc(t + 12);

        // Flush during playback with entries queued, then restart.
        t = cyc;
        expect_ev(EV_START, 8'h33, t + 3);
        drive_push(8'h33);
        drive_push(8'h44);
        drive_push(8'h55);
        to_cyc(t + 4);
        chk("t4_count_pre", queue_count, 2);
        expect_ev(EV_ABORT, 8'h00, t + 5);
        pulse_flush();
        chk("t4_count_post", queue_count, 0);
        pulse_done();
        to_cyc(t + 8);
        chk("t4_busy_idle", busy, 0);
        expect_ev(EV_START, 8'h66, t + 11);
        drive_push(8'h66);
        to_cyc(t + 13);
        expect_ev(EV_IRQ, 8'h00, t + 18);
        pulse_done();
        to_cyc(t + 20);

        // Stray done in GAP, then push coincident with flush.
        t = cyc;
        expect_ev(EV_START, 8'h77, t + 3);
        drive_push(8'h77);
        to_cyc(t + 5);
        expect_ev(EV_IRQ, 8'h00, t + 10);
        pulse_done();
        to_cyc(t + 7);
        pulse_done();
        to_cyc(t + 12);
        push_valid   = 1'b1;
        push_phoneme = 8'h88;
        flush        = 1'b1;
        @(negedge clk);
        push_valid = 1'b0;
        flush      = 1'b0;
        chk("t5_count_drop", queue_count, 0);
        chk("t5_ovf_drop", overflow, 0);
        chk("t5_busy_drop", busy, 0);
        to_cyc(t + 16);

        // Reset in the middle of a pause with three entries queued.
        t = cyc;
        codes[0] = DEFAULT_SILENCE_CODE;
        codes[1] = 8'h01;
        codes[2] = 8'h02;
        codes[3] = 8'h03;
        for (int i = 0; i < 4; i++) drive_push(codes[i]);
        chk("t6_count_pre", queue_count, 3);
        chk("t6_busy_pre", busy, 1);
        to_cyc(t + 6);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        t = cyc;
        expect_ev(EV_START, 8'h0A, t + 3);
        drive_push(8'h0A);
        to_cyc(t + 5);
        expect_ev(EV_IRQ, 8'h00, t + 10);
        pulse_done();
        to_cyc(t + 14);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missing_event: got none, expected kind %0d data %0h cyc %0d",
                     e.kind, e.data, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
